// File: rtl/rtc_backup_serializer.sv
// Snapshots the mapper's live RTC buses and streams them as six 16-bit backup words
// (timestamp, saved-time vector, XOR checksum) over a valid/ready handshake.
module rtc_backup_serializer (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        save_req,
    input  logic [31:0] rtc_timestamp,
    input  logic [47:0] rtc_savedtime,
    output logic        bk_rtc_valid,
    input  logic        bk_rtc_ready,
    output logic [7:0]  bk_rtc_addr,
    output logic [15:0] bk_rtc_data,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] ts_q, ts_d;
    logic [47:0] st_q, st_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic [15:0] word_sel;
    logic [15:0] checksum;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge; blocking here would create order-dependent races.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            ts_q      <= 32'd0;
            st_q      <= 48'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ts_q      <= ts_d;
            st_q      <= st_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // NOTE: every next-state signal gets a default before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ts_d      = ts_q;
        st_d      = st_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (save_req && enable) begin
                    state_d = ST_SNAP;
                end
            end

            ST_SNAP: begin
                if (!enable) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    // Both buses latched on the same edge so the backup is coherent.
                    ts_d    = rtc_timestamp;
                    st_d    = rtc_savedtime;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                // Losing enable outranks a simultaneous final acceptance.
                if (!enable) begin
                    state_d   = ST_IDLE;
                    idx_d     = 3'd0;
                    aborted_d = 1'b1;
                end else if (bk_rtc_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    assign checksum = ts_q[15:0] ^ ts_q[31:16] ^ st_q[15:0] ^ st_q[31:16] ^ st_q[47:32];

    always_comb begin
        word_sel = 16'd0;
        case (idx_q)
            3'd0:    word_sel = ts_q[15:0];
            3'd1:    word_sel = ts_q[31:16];
            3'd2:    word_sel = st_q[15:0];
            3'd3:    word_sel = st_q[31:16];
            3'd4:    word_sel = st_q[47:32];
            3'd5:    word_sel = checksum;
            default: word_sel = 16'd0;
        endcase
    end

    // Outputs decode registered state only; ready never reaches them combinationally.
    assign bk_rtc_valid = (state_q == ST_SEND);
    assign bk_rtc_addr  = {5'd0, idx_q};
    assign bk_rtc_data  = bk_rtc_valid ? word_sel : 16'd0;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_rtc_backup_serializer.sv
// Directed bench for rtc_backup_serializer: dump order, backpressure, snapshot
// coherence, abort, request rules and asynchronous reset.
module tb_rtc_backup_serializer;

    typedef logic [15:0] words_t [6];

    logic        clk_sys;
    logic        reset_n;
    logic        enable;
    logic        save_req;
    logic [31:0] rtc_timestamp;
    logic [47:0] rtc_savedtime;
    logic        bk_rtc_valid;
    logic        bk_rtc_ready;
    logic [7:0]  bk_rtc_addr;
    logic [15:0] bk_rtc_data;
    logic        busy;
    logic        done;
    logic        aborted;

    int checks = 0;
    int errors = 0;

    rtc_backup_serializer dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .enable        (enable),
        .save_req      (save_req),
        .rtc_timestamp (rtc_timestamp),
        .rtc_savedtime (rtc_savedtime),
        .bk_rtc_valid  (bk_rtc_valid),
        .bk_rtc_ready  (bk_rtc_ready),
        .bk_rtc_addr   (bk_rtc_addr),
        .bk_rtc_data   (bk_rtc_data),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   64'(bk_rtc_valid), 64'd0);
        check({tag, "_busy"},    64'(busy),         64'd0);
        check({tag, "_done"},    64'(done),         64'd0);
        check({tag, "_aborted"}, 64'(aborted),      64'd0);
        check({tag, "_addr"},    64'(bk_rtc_addr),  64'd0);
        check({tag, "_data"},    64'(bk_rtc_data),  64'd0);
    endtask

    // Request sampled at E0 (SNAP after it), snapshot at E1, word 0 presented after E1.
    task automatic start_dump(input string tag);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        check({tag, "_snap_busy"},  64'(busy),         64'd1);
        check({tag, "_snap_valid"}, 64'(bk_rtc_valid), 64'd0);
        step();
    endtask

    task automatic run_words(input string tag, input words_t w, input int first, input int last,
                             input int stall_at, input int stall_n, input bit scramble,
                             input int req_at);
        for (int i = first; i <= last; i++) begin
            if (i == stall_at) begin
                bk_rtc_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    check({tag, "_stall_valid"}, 64'(bk_rtc_valid), 64'd1);
                    check({tag, "_stall_addr"},  64'(bk_rtc_addr),  64'(i));
                    check({tag, "_stall_data"},  64'(bk_rtc_data),  64'(w[i]));
                    step();
                end
                bk_rtc_ready = 1'b1;
            end
            check({tag, "_valid"}, 64'(bk_rtc_valid), 64'd1);
            check({tag, "_addr"},  64'(bk_rtc_addr),  64'(i));
            check({tag, "_data"},  64'(bk_rtc_data),  64'(w[i]));
            check({tag, "_nodone"}, 64'(done),        64'd0);
            if (i == req_at) save_req = 1'b1;
            if (scramble) begin
                rtc_timestamp = $urandom;
                rtc_savedtime = {16'($urandom), $urandom};
            end
            step();
            if (i == req_at) save_req = 1'b0;
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},    64'(done),         64'd1);
        check({tag, "_busy"},    64'(busy),         64'd0);
        check({tag, "_valid"},   64'(bk_rtc_valid), 64'd0);
        check({tag, "_aborted"}, 64'(aborted),      64'd0);
    endtask

    // Word tables; checksum is the XOR of words 0-4 (0x21AB^0x6543^0x4567^0x0123 = 0x00AC).
    words_t basic_w = '{16'h21AB, 16'h6543, 16'h4567, 16'h0123, 16'h0000, 16'h00AC};
    words_t bp_w    = '{16'hBEEF, 16'hDEAD, 16'h9ABC, 16'h5678, 16'h1234, 16'hBEB2};
    words_t coh_w   = '{16'hF00D, 16'h0BAD, 16'h2468, 16'h1357, 16'hCAFE, 16'h0661};

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        save_req      = 1'b0;
        bk_rtc_ready  = 1'b1;
        rtc_timestamp = 32'd0;
        rtc_savedtime = 48'd0;
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();
        check("post_reset_busy", 64'(busy), 64'd0);

        // Basic dump, ready tied high.
        enable        = 1'b1;
        rtc_timestamp = 32'h6543_21AB;
        rtc_savedtime = 48'h0000_0123_4567;
        start_dump("basic");
        run_words("basic", basic_w, 0, 5, -1, 0, 1'b0, -1);
        check_done("basic_end");
        step();
        check("basic_done_pulse", 64'(done), 64'd0);
        check("basic_idle_busy",  64'(busy), 64'd0);

        // Backpressure: ready low for 3 cycles on word 2.
        rtc_timestamp = 32'hDEAD_BEEF;
        rtc_savedtime = 48'h1234_5678_9ABC;
        start_dump("bp");
        run_words("bp", bp_w, 0, 5, 2, 3, 1'b0, -1);
        check_done("bp_end");
        step();

        // Snapshot coherence: live inputs scrambled every cycle after SNAP.
        rtc_timestamp = 32'h0BAD_F00D;
        rtc_savedtime = 48'hCAFE_1357_2468;
        start_dump("coh");
        run_words("coh", coh_w, 0, 5, -1, 0, 1'b1, -1);
        check_done("coh_end");
        step();

        // Abort while word 3 is presented, then a fresh dump from word 0.
        rtc_timestamp = 32'h6543_21AB;
        rtc_savedtime = 48'h0000_0123_4567;
        start_dump("abort");
        run_words("abort", basic_w, 0, 2, -1, 0, 1'b0, -1);
        check("abort_at_addr", 64'(bk_rtc_addr), 64'd3);
        enable = 1'b0;
        step();
        check("abort_pulse",   64'(aborted),      64'd1);
        check("abort_valid",   64'(bk_rtc_valid), 64'd0);
        check("abort_busy",    64'(busy),         64'd0);
        check("abort_no_done", 64'(done),         64'd0);
        step();
        check("abort_pulse_end", 64'(aborted), 64'd0);
        check("abort_no_done2",  64'(done),    64'd0);
        enable = 1'b1;
        start_dump("restart");
        run_words("restart", basic_w, 0, 5, -1, 0, 1'b0, -1);
        check_done("restart_end");
        step();

        // A request pulse during SEND is ignored: exactly six words.
        start_dump("pulse");
        run_words("pulse", basic_w, 0, 5, -1, 0, 1'b0, 2);
        check_done("pulse_end");
        step();
        check("pulse_no_rerun_busy",  64'(busy),         64'd0);
        check("pulse_no_rerun_valid", 64'(bk_rtc_valid), 64'd0);

        // Held request: back-to-back dumps, each preceded by SNAP.
        save_req = 1'b1;
        step();
        check("held_snap1_busy", 64'(busy), 64'd1);
        step();
        run_words("held1", basic_w, 0, 5, -1, 0, 1'b0, -1);
        check_done("held1_end");
        step();
        check("held_snap2_busy",  64'(busy),         64'd1);
        check("held_snap2_valid", 64'(bk_rtc_valid), 64'd0);
        check("held_snap2_done",  64'(done),         64'd0);
        save_req = 1'b0;
        step();
        run_words("held2", basic_w, 0, 5, -1, 0, 1'b0, -1);
        check_done("held2_end");
        step();
        check("held_stop_busy", 64'(busy), 64'd0);

        // Asynchronous reset while word 4 is presented, between clock edges.
        start_dump("arst");
        run_words("arst", basic_w, 0, 3, -1, 0, 1'b0, -1);
        check("arst_at_addr", 64'(bk_rtc_addr), 64'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        step();
        step();
        #2;
        reset_n = 1'b1;
        step();
        step();
        step();
        check_reset_outputs("arst_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
